// File: rtl/jno_pkg.sv
// Shared constants for the paper-processor sequencer: opcodes, FSM state
// encoding and instruction-word field offsets.
package jno_pkg;

    typedef logic [1:0] op_t;

    localparam op_t OP_INC = 2'b00;
    localparam op_t OP_DEC = 2'b01;
    localparam op_t OP_HLT = 2'b10;
    localparam op_t OP_JNO = 2'b11;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_FETCH  = 2'd1;
    localparam logic [1:0] ST_EXEC   = 2'd2;
    localparam logic [1:0] ST_HALTED = 2'd3;

    // Instruction word is [op(2) | reg(RW) | tgt(AW)], target in the low bits.
    localparam int TGT_LSB = 0;

    function automatic int reg_lsb(input int aw);
        return aw;
    endfunction

    function automatic int op_lsb(input int rw, input int aw);
        return rw + aw;
    endfunction

endpackage

// File: rtl/jno_sequencer_if.sv
// Program-memory fetch channel: the sequencer (master) requests a word at
// mem_addr and memory (slave) answers with mem_ack and mem_data.
interface jno_sequencer_if #(
    parameter int AW = 4,
    parameter int RW = 2
);
    localparam int IW = 2 + RW + AW;

    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ack;
    logic [IW-1:0] mem_data;

    modport master (output mem_req, output mem_addr, input mem_ack, input mem_data);
    modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_data);
endinterface

// File: rtl/jno_regfile.sv
// Register file for the sequencer: one increment/decrement write port, a
// combinational operand read and an independent debug read.
module jno_regfile #(
    parameter int RW = 2,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc_en,
    input  logic          dec_en,
    input  logic [RW-1:0] r,
    output logic [DW-1:0] r_val,
    input  logic [RW-1:0] dbg_sel,
    output logic [DW-1:0] dbg_val
);
    localparam int NREG = 2 ** RW;

    logic [DW-1:0] regs [NREG];

    // Wrap-around in both directions falls out of modulo-2**DW arithmetic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (inc_en) begin
            regs[r] <= regs[r] + DW'(1);
        end else if (dec_en) begin
            regs[r] <= regs[r] - DW'(1);
        end
    end

    assign r_val   = regs[r];
    assign dbg_val = regs[dbg_sel];

endmodule

// File: rtl/jno_sequencer.sv
// Fetch/execute sequencer for the paper processor; drives the registered
// instruct code consumed by the clock-halt gate.
module jno_sequencer
    import jno_pkg::*;
#(
    parameter int AW = 4,
    parameter int RW = 2,
    parameter int DW = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    jno_sequencer_if.master        mem,
    input  logic                   resume,
    output logic [1:0]             instruct,
    output logic                   halted,
    output logic [AW-1:0]          pc,
    input  logic [RW-1:0]          reg_sel,
    output logic [DW-1:0]          reg_val
);
    localparam int IW      = 2 + RW + AW;
    localparam int OP_LSB  = op_lsb(RW, AW);
    localparam int REG_LSB = reg_lsb(AW);

    logic [1:0]    state;
    logic [IW-1:0] ir;
    op_t           ir_op;
    logic [RW-1:0] ir_reg;
    logic [AW-1:0] ir_tgt;
    logic [DW-1:0] r_val;
    logic          exec;

    assign ir_op  = ir[OP_LSB +: 2];
    assign ir_reg = ir[REG_LSB +: RW];
    assign ir_tgt = ir[TGT_LSB +: AW];
    assign exec   = (state == ST_EXEC);

    assign mem.mem_req  = (state == ST_FETCH);
    assign mem.mem_addr = pc;

    jno_regfile #(.RW(RW), .DW(DW)) u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_en  (exec && (ir_op == OP_INC)),
        .dec_en  (exec && (ir_op == OP_DEC)),
        .r       (ir_reg),
        .r_val   (r_val),
        .dbg_sel (reg_sel),
        .dbg_val (reg_val)
    );

    // instruct is loaded together with ir so the halt gate sees a flop output
    // that is stable from the EXEC cycle until the next fetch completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            pc       <= '0;
            ir       <= '0;
            instruct <= OP_INC;
            halted   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: state <= ST_FETCH;
                ST_FETCH: begin
                    if (mem.mem_ack) begin
                        ir       <= mem.mem_data;
                        instruct <= mem.mem_data[OP_LSB +: 2];
                        state    <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    case (ir_op)
                        OP_INC, OP_DEC: begin
                            pc    <= pc + AW'(1);
                            state <= ST_FETCH;
                        end
                        OP_JNO: begin
                            pc    <= (r_val == '0) ? ir_tgt : pc + AW'(1);
                            state <= ST_FETCH;
                        end
                        OP_HLT: begin
                            halted <= 1'b1;
                            state  <= ST_HALTED;
                        end
                    endcase
                end
                ST_HALTED: begin
                    if (resume) begin
                        pc     <= pc + AW'(1);
                        halted <= 1'b0;
                        state  <= ST_FETCH;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jno_sequencer.sv
// Self-checking bench for jno_sequencer: table of small programs with
// hand-derived results, corner-case sequences and random programs vs an ISA model.
module tb_jno_sequencer;
    import jno_pkg::*;

    localparam int AW = 4, RW = 2, DW = 8, IW = 8, DEPTH = 16, NREG = 4, NV = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          resume = 1'b0;
    logic [1:0]    instruct;
    logic          halted;
    logic [AW-1:0] pc;
    logic [RW-1:0] reg_sel = '0;
    logic [DW-1:0] reg_val;

    jno_sequencer_if #(.AW(AW), .RW(RW)) mem ();

    jno_sequencer #(.AW(AW), .RW(RW), .DW(DW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mem      (mem),
        .resume   (resume),
        .instruct (instruct),
        .halted   (halted),
        .pc       (pc),
        .reg_sel  (reg_sel),
        .reg_val  (reg_val)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [IW-1:0] prog [DEPTH];
        int            waitCycles;
        int            expPc;
        int            expReg [NREG];
    } vec_t;

    vec_t          vecs [NV];
    logic [IW-1:0] image [DEPTH];
    int            errors = 0;
    int            checks = 0;
    int            mPc;
    int            mReg [NREG];
    bit            mHalted;
    bit            timedOut = 1'b0;

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [IW-1:0] enc(input int op, input int r, input int tgt);
        return {2'(op), 2'(r), 4'(tgt)};
    endfunction

    // Instruction-level reference model of the processor.
    task automatic modelExec(input logic [IW-1:0] w);
        int op  = int'(w[7:6]);
        int r   = int'(w[5:4]);
        int tgt = int'(w[3:0]);
        case (op)
            0: begin mReg[r] = (mReg[r] + 1) % 256;   mPc = (mPc + 1) % DEPTH; end
            1: begin mReg[r] = (mReg[r] + 255) % 256; mPc = (mPc + 1) % DEPTH; end
            2: mHalted = 1'b1;
            default: mPc = (mReg[r] == 0) ? tgt : (mPc + 1) % DEPTH;
        endcase
    endtask

    task automatic modelReset();
        mPc = 0;
        mHalted = 1'b0;
        for (int i = 0; i < NREG; i++) mReg[i] = 0;
    endtask

    task automatic applyReset();
        rst_n = 1'b0;
        mem.mem_ack = 1'b0;
        resume = 1'b0;
        #1;
        checkOutput("rst_pc", int'(pc), 0);
        checkOutput("rst_req", int'(mem.mem_req), 0);
        checkOutput("rst_halted", int'(halted), 0);
        checkOutput("rst_instruct", int'(instruct), 0);
        modelReset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Serves one fetch with the given memory wait, then checks the EXEC and
    // post-EXEC cycles against the model.
    task automatic applyStimulus(input int waitCycles);
        int            n = 0;
        logic [IW-1:0] w;
        int            op, r;
        while (!mem.mem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!mem.mem_req) begin
            checkOutput("fetch_timeout", 0, 1);
            timedOut = 1'b1;
            return;
        end
        checkOutput("fetch_addr", int'(mem.mem_addr), mPc);
        w  = image[mem.mem_addr];
        op = int'(w[7:6]);
        r  = int'(w[5:4]);
        for (int i = 0; i < waitCycles; i++) begin
            resume = 1'($urandom_range(0, 1));
            @(negedge clk);
            checkOutput("stall_req", int'(mem.mem_req), 1);
            checkOutput("stall_addr", int'(mem.mem_addr), mPc);
        end
        resume = 1'b0;
        mem.mem_ack = 1'b1;
        mem.mem_data = w;
        @(negedge clk);
        mem.mem_ack = 1'b0;
        mem.mem_data = 8'($urandom);
        checkOutput("exec_instruct", int'(instruct), op);
        checkOutput("exec_req_drop", int'(mem.mem_req), 0);
        resume = (op == 2) ? 1'b1 : 1'($urandom_range(0, 1));
        modelExec(w);
        @(negedge clk);
        resume = 1'b0;
        reg_sel = 2'(r);
        #1;
        checkOutput("post_reg", int'(reg_val), mReg[r]);
        checkOutput("post_pc", int'(pc), mPc);
        checkOutput("post_halted", int'(halted), int'(mHalted));
    endtask

    task automatic resumeFromHalt();
        int k = $urandom_range(1, 3);
        for (int i = 0; i < k; i++) begin
            mem.mem_ack = 1'($urandom_range(0, 1));
            mem.mem_data = 8'($urandom);
            @(negedge clk);
            checkOutput("halt_flag", int'(halted), 1);
            checkOutput("halt_noreq", int'(mem.mem_req), 0);
            checkOutput("halt_instruct", int'(instruct), 2);
            checkOutput("halt_pc", int'(pc), mPc);
        end
        mem.mem_ack = 1'b0;
        resume = 1'b1;
        @(negedge clk);
        resume = 1'b0;
        mPc = (mPc + 1) % DEPTH;
        mHalted = 1'b0;
        checkOutput("resume_halted", int'(halted), 0);
        checkOutput("resume_pc", int'(pc), mPc);
    endtask

    task automatic runUntilHalt(input int budget, input int waitCycles);
        for (int i = 0; i < budget && !mHalted && !timedOut; i++) applyStimulus(waitCycles);
    endtask

    task automatic checkRegs(input string tag, input int e0, input int e1, input int e2, input int e3);
        int exp [NREG];
        exp = '{e0, e1, e2, e3};
        for (int i = 0; i < NREG; i++) begin
            reg_sel = 2'(i);
            #1;
            checkOutput($sformatf("%s_r%0d", tag, i), int'(reg_val), exp[i]);
        end
    endtask

    initial begin
        mem.mem_ack = 1'b0;
        mem.mem_data = '0;

        for (int v = 0; v < NV; v++) begin
            vecs[v].prog = '{default: 8'h80};
            vecs[v].waitCycles = 0;
            vecs[v].expReg = '{0, 0, 0, 0};
        end
        vecs[0].prog[0] = enc(0, 0, 0); vecs[0].prog[1] = enc(0, 0, 0);
        vecs[0].waitCycles = 1; vecs[0].expPc = 2; vecs[0].expReg = '{2, 0, 0, 0};
        vecs[1].prog[0] = enc(1, 1, 0);
        vecs[1].expPc = 1; vecs[1].expReg = '{0, 255, 0, 0};
        vecs[2].prog[0] = enc(1, 1, 0); vecs[2].prog[1] = enc(0, 1, 0);
        vecs[2].waitCycles = 2; vecs[2].expPc = 2;
        vecs[3].prog[0] = enc(3, 2, 4);
        vecs[3].expPc = 4;
        for (int i = 0; i < 3; i++) vecs[4].prog[i] = enc(0, 2, 0);
        vecs[4].prog[3] = enc(3, 2, 7);
        vecs[4].expPc = 4; vecs[4].expReg = '{0, 0, 3, 0};
        vecs[5].prog[0] = enc(0, 3, 0);
        vecs[5].waitCycles = 5; vecs[5].expPc = 1; vecs[5].expReg = '{0, 0, 0, 1};
        vecs[6].prog[0] = enc(3, 0, 15); vecs[6].prog[15] = enc(0, 0, 0);
        vecs[6].expPc = 1; vecs[6].expReg = '{1, 0, 0, 0};
        vecs[7].prog[0] = enc(0, 1, 0); vecs[7].prog[1] = enc(0, 1, 0);
        vecs[7].prog[2] = enc(1, 1, 0); vecs[7].prog[3] = enc(3, 1, 5);
        vecs[7].prog[4] = enc(3, 0, 2);
        vecs[7].expPc = 5;

        for (int v = 0; v < NV && !timedOut; v++) begin
            image = vecs[v].prog;
            applyReset();
            runUntilHalt(40, vecs[v].waitCycles);
            checkOutput($sformatf("vec%0d_halted", v), int'(halted), 1);
            checkOutput($sformatf("vec%0d_instruct", v), int'(instruct), 2);
            checkOutput($sformatf("vec%0d_pc", v), int'(pc), vecs[v].expPc);
            checkRegs($sformatf("vec%0d", v), vecs[v].expReg[0], vecs[v].expReg[1],
                      vecs[v].expReg[2], vecs[v].expReg[3]);
        end

        // JNO onto its own address with a zero register keeps fetching address 0.
        image = '{default: 8'h80};
        image[0] = enc(3, 0, 0);
        applyReset();
        for (int i = 0; i < 4 && !timedOut; i++) applyStimulus(0);
        checkOutput("selfloop_pc", int'(pc), 0);

        // Halt, resume, continue to the next halt.
        image = '{default: 8'h80};
        image[1] = enc(0, 0, 0);
        applyReset();
        runUntilHalt(5, 1);
        checkOutput("hr_first_pc", int'(pc), 0);
        resumeFromHalt();
        runUntilHalt(5, 0);
        checkOutput("hr_final_pc", int'(pc), 2);
        checkRegs("hr", 1, 0, 0, 0);

        // Asynchronous reset in the middle of a stalled fetch with an ack in flight.
        image = '{default: 8'h80};
        image[0] = enc(0, 1, 0); image[1] = enc(0, 1, 0); image[2] = enc(0, 2, 0);
        applyReset();
        applyStimulus(0);
        applyStimulus(0);
        @(negedge clk);
        mem.mem_ack = 1'b1;
        mem.mem_data = image[2];
        #2 rst_n = 1'b0;
        #1;
        checkOutput("arst_req", int'(mem.mem_req), 0);
        checkOutput("arst_pc", int'(pc), 0);
        checkOutput("arst_halted", int'(halted), 0);
        checkRegs("arst", 0, 0, 0, 0);
        mem.mem_ack = 1'b0;
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;
        runUntilHalt(10, 1);
        checkOutput("arst_final_pc", int'(pc), 3);
        checkRegs("arst_final", 0, 2, 1, 0);

        // Random programs checked instruction by instruction against the model.
        for (int t = 0; t < 4 && !timedOut; t++) begin
            for (int a = 0; a < DEPTH; a++) image[a] = 8'($urandom);
            applyReset();
            for (int n = 0; n < 40 && !timedOut; n++) begin
                applyStimulus($urandom_range(0, 3));
                if (mHalted && !timedOut) resumeFromHalt();
            end
            checkRegs($sformatf("rand%0d", t), mReg[0], mReg[1], mReg[2], mReg[3]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
